// File: rtl/mul_chain_sched.sv
// Shares one six-lane FP32 multiplier chain between NREQ requesters: round-robin issue,
// mode locking with drain-before-switch, and in-order result routing through an owner-tag FIFO.
module mul_chain_sched #(
  parameter int NREQ      = 4,
  parameter int TAG_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*384-1:0]   req_data,
  input  logic [NREQ*2-1:0]     req_mode,
  output logic [383:0]          mul_ins,
  output logic                  mul_stb,
  output logic [1:0]            mode,
  input  logic [191:0]          chain_outputs,
  input  logic [5:0]            chain_stbs,
  output logic [NREQ-1:0]       resp_valid,
  output logic [191:0]          resp_data,
  output logic [5:0]            resp_lanes,
  output logic                  busy,
  output logic                  err_spurious
);
  localparam int IDX_W = $clog2(NREQ);
  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_SWITCH} state_t;

  state_t             r_state;
  state_t             w_state_nx;
  logic [1:0]         r_mode;
  logic [IDX_W-1:0]   r_rr;
  logic [CNT_W-1:0]   r_out;
  logic [CNT_W-1:0]   w_out_nx;
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [IDX_W-1:0]   r_tags [TAG_DEPTH];
  logic [IDX_W-1:0]   r_pend_owner;
  logic [1:0]         r_pend_mode;
  logic               r_busy;
  logic               r_err;

  logic               r_stb_p1;
  logic [383:0]       r_mul_ins_p1;
  logic [NREQ-1:0]    r_resp_vld_p1;
  logic [191:0]       r_resp_data_p1;
  logic [5:0]         r_resp_lanes_p1;

  logic [383:0]       w_data  [NREQ];
  logic [1:0]         w_rmode [NREQ];
  logic               w_cand_vld;
  logic [IDX_W-1:0]   w_cand;
  logic               w_mode_ok;
  logic               w_full;
  logic               w_grant;
  logic               w_lock;
  logic               w_accept;
  logic               w_res_evt;
  logic               w_pop;
  logic               w_drained;

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_data[g]  = req_data[g*384 +: 384];
    assign w_rmode[g] = req_mode[g*2 +: 2];
  end

  // First valid requester at or after the round-robin pointer, wrapping around.
  always_comb begin
    w_cand_vld = 1'b0;
    w_cand     = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_cand_vld && req_valid[IDX_W'((int'(r_rr) + k) % NREQ)]) begin
        w_cand_vld = 1'b1;
        w_cand     = IDX_W'((int'(r_rr) + k) % NREQ);
      end
    end
  end

  assign w_mode_ok = (w_rmode[w_cand] == r_mode);
  assign w_full    = (r_out == CNT_W'(TAG_DEPTH));
  assign w_res_evt = |chain_stbs;
  assign w_pop     = w_res_evt && (r_out != '0);
  // Drain completion looks only at completions; no issue can happen outside RUN.
  assign w_drained = (r_out == '0) || ((r_out == CNT_W'(1)) && w_pop);

  always_comb begin
    w_state_nx = r_state;
    w_grant    = 1'b0;
    w_lock     = 1'b0;
    case (r_state)
      S_RUN: begin
        if (w_cand_vld) begin
          if (!w_mode_ok) begin
            w_lock     = 1'b1;
            w_state_nx = S_DRAIN;
          end else if (!w_full) begin
            w_grant = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (w_drained) w_state_nx = S_SWITCH;
      end
      S_SWITCH: w_state_nx = S_RUN;
      default:  w_state_nx = S_RUN;
    endcase
  end

  assign w_accept  = w_grant & rst;
  assign req_ready = w_accept ? (NREQ'(1) << w_cand) : '0;

  always_comb begin
    w_out_nx = r_out;
    if (w_accept && !w_pop)      w_out_nx = r_out + 1'b1;
    else if (!w_accept && w_pop) w_out_nx = r_out - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_RUN;
      r_mode        <= 2'b11;
      r_rr          <= '0;
      r_out         <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_pend_owner  <= '0;
      r_pend_mode   <= 2'b11;
      r_busy        <= 1'b0;
      r_err         <= 1'b0;
      r_stb_p1      <= 1'b0;
      r_resp_vld_p1 <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_out    <= w_out_nx;
      r_busy   <= (w_out_nx != '0);
      r_stb_p1 <= w_accept;
      if (w_accept) begin
        r_wptr <= r_wptr + 1'b1;
        r_rr   <= (w_cand == IDX_W'(NREQ - 1)) ? '0 : w_cand + 1'b1;
      end else if (r_state == S_SWITCH) begin
        r_rr <= r_pend_owner;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_lock) begin
        r_pend_owner <= w_cand;
        r_pend_mode  <= w_rmode[w_cand];
      end
      if (r_state == S_SWITCH) r_mode <= r_pend_mode;
      if (w_res_evt && (r_out == '0)) r_err <= 1'b1;
      r_resp_vld_p1 <= w_pop ? (NREQ'(1) << r_tags[r_rptr]) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) r_tags[r_wptr] <= w_cand;
  end

  // Stage p1: issue bundle and routed result registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mul_ins_p1    <= '0;
      r_resp_data_p1  <= '0;
      r_resp_lanes_p1 <= '0;
    end else begin
      if (w_accept) r_mul_ins_p1 <= w_data[w_cand];
      if (w_pop) begin
        r_resp_data_p1  <= chain_outputs;
        r_resp_lanes_p1 <= chain_stbs;
      end
    end
  end

  assign mul_ins      = r_mul_ins_p1;
  assign mul_stb      = r_stb_p1;
  assign mode         = r_mode;
  assign resp_valid   = r_resp_vld_p1;
  assign resp_data    = r_resp_data_p1;
  assign resp_lanes   = r_resp_lanes_p1;
  assign busy         = r_busy;
  assign err_spurious = r_err;

endmodule

// File: tb/tb_mul_chain_sched.sv
// Scoreboard bench for mul_chain_sched with a behavioural fixed-latency chain model.
module tb_mul_chain_sched;
  localparam int NREQ      = 4;
  localparam int TAG_DEPTH = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*384-1:0] req_data = '0;
  logic [NREQ*2-1:0]   req_mode = '1;
  logic [383:0]        mul_ins;
  logic                mul_stb;
  logic [1:0]          mode;
  logic [191:0]        chain_outputs = '0;
  logic [5:0]          chain_stbs = '0;
  logic [NREQ-1:0]     resp_valid;
  logic [191:0]        resp_data;
  logic [5:0]          resp_lanes;
  logic                busy;
  logic                err_spurious;

  mul_chain_sched #(.NREQ(NREQ), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_mode(req_mode),
    .mul_ins(mul_ins), .mul_stb(mul_stb), .mode(mode),
    .chain_outputs(chain_outputs), .chain_stbs(chain_stbs),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_lanes(resp_lanes),
    .busy(busy), .err_spurious(err_spurious)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           due;
    logic [191:0] val;
  } job_t;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         lat = 9;
  int         model_out = 0;
  int         last_res = -1;
  bit         exp_err = 1'b0;
  logic [5:0] inj_stbs = '0;
  job_t       pipe[$];
  int         own_q[$];

  task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [383:0] rnd384();
    logic [383:0] v;
    for (int i = 0; i < 12; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One clock: record handshake, advance, check registered outputs, drive the chain model.
  task automatic tick();
    logic [NREQ-1:0] acc;
    logic [383:0]    adata;
    logic [191:0]    f_out;
    logic [5:0]      f_lanes;
    logic [1:0]      mode_b;
    bit              in_rst;
    bit              fired;
    int              out_b;
    int              o;
    acc     = req_valid & req_ready;
    in_rst  = !rst;
    fired   = (chain_stbs != '0);
    f_out   = chain_outputs;
    f_lanes = chain_stbs;
    mode_b  = mode;
    out_b   = model_out;
    adata   = '0;
    chk("ready_onehot", 384'($onehot0(req_ready)), 384'(1));
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        own_q.push_back(i);
        adata = req_data[i*384 +: 384];
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (in_rst) begin
      pipe.delete();
      own_q.delete();
      model_out = 0;
      exp_err   = 1'b0;
      chk("rst_stb", 384'(mul_stb), 384'(0));
      chk("rst_ins", mul_ins, 384'(0));
      chk("rst_rvld", 384'(resp_valid), 384'(0));
      chk("rst_rdata", 384'(resp_data), 384'(0));
      chk("rst_rlanes", 384'(resp_lanes), 384'(0));
      chk("rst_busy", 384'(busy), 384'(0));
      chk("rst_err", 384'(err_spurious), 384'(0));
      chk("rst_mode", 384'(mode), 384'(3));
    end else begin
      if (acc != '0) model_out++;
      if (fired) begin
        if (out_b > 0) model_out--;
        else exp_err = 1'b1;
      end
      chk("stb", 384'(mul_stb), 384'(acc != '0));
      if (acc != '0) chk("ins", mul_ins, adata);
      if (fired && out_b > 0) begin
        o = (own_q.size() > 0) ? own_q.pop_front() : 0;
        chk("resp_vld", 384'(resp_valid), 384'(NREQ'(1) << o));
        chk("resp_data", 384'(resp_data), 384'(f_out));
        chk("resp_lanes", 384'(resp_lanes), 384'(f_lanes));
      end else begin
        chk("resp_idle", 384'(resp_valid), 384'(0));
      end
      chk("busy", 384'(busy), 384'(model_out != 0));
      chk("err", 384'(err_spurious), 384'(exp_err));
      chk("cap", 384'(model_out <= TAG_DEPTH), 384'(1));
      if (out_b != 0) chk("mode_hold", 384'(mode), 384'(mode_b));
      if (mul_stb) pipe.push_back('{cyc + lat, mul_ins[191:0] ^ mul_ins[383:192]});
    end
    if (pipe.size() > 0 && pipe[0].due <= cyc) begin
      chain_outputs = pipe[0].val;
      chain_stbs    = 6'($urandom_range(1, 63));
      void'(pipe.pop_front());
      last_res      = cyc;
    end else begin
      chain_outputs = {6{32'(cyc)}};
      chain_stbs    = inj_stbs;
    end
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((model_out != 0 || pipe.size() != 0) && n < 200) begin
      tick();
      n++;
    end
    chk("drain_timeout", 384'(model_out), 384'(0));
    repeat (2) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    bit seen;
    bit saw_full;
    int gcyc;

    // Reset: grants are forced low even with requests present.
    rst = 1'b0;
    repeat (2) tick();
    req_valid = '1;
    #1;
    chk("rst_ready", 384'(req_ready), 384'(0));
    tick();
    req_valid = '0;
    rst = 1'b1;
    while (cyc < 10) tick();

    // Single job: accepted at cycle 10, result back at 20, response at 21.
    lat = 9;
    req_data[383:0] = rnd384();
    req_valid = 4'b0001;
    #1;
    chk("t1_ready", 384'(req_ready), 384'(4'b0001));
    tick();
    req_valid = '0;
    drain();

    // Round-robin with all requesters asserting continuously.
    lat = 3;
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < NREQ; i++) req_data[i*384 +: 384] = rnd384();
      #1;
      chk("rr_grant", 384'(req_ready), 384'(NREQ'(1) << ((1 + k) % NREQ)));
      tick();
    end
    req_valid = '0;
    drain();

    // Full tag FIFO: long latency, single requester.
    lat = 20;
    saw_full = 1'b0;
    req_valid = 4'b0100;
    for (int k = 0; k < 40; k++) begin
      req_data[2*384 +: 384] = rnd384();
      #1;
      if (model_out >= TAG_DEPTH) saw_full = 1'b1;
      chk("full_ready", 384'(req_ready), 384'((model_out < TAG_DEPTH) ? 4'b0100 : 4'b0000));
      tick();
    end
    chk("full_hit", 384'(saw_full), 384'(1));
    req_valid = '0;
    drain();

    // Mode switch with three mode-11 jobs in flight.
    lat = 10;
    req_valid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      req_data[383:0] = rnd384();
      #1;
      chk("ms_pre", 384'(req_ready), 384'(4'b0001));
      tick();
    end
    req_valid = 4'b0010;
    req_mode[3:2] = 2'b01;
    req_data[384 +: 384] = rnd384();
    seen = 1'b0;
    gcyc = -1;
    for (int n = 0; n < 60 && !seen; n++) begin
      #1;
      if (req_ready[1]) begin
        seen = 1'b1;
        gcyc = cyc;
      end else begin
        chk("ms_block", 384'(req_ready), 384'(0));
        chk("ms_mode_old", 384'(mode), 384'(2'b11));
        tick();
      end
    end
    chk("ms_seen", 384'(seen), 384'(1));
    chk("ms_mode_new", 384'(mode), 384'(2'b01));
    chk("ms_latency", 384'(gcyc), 384'(last_res + 2));
    tick();
    req_valid = '0;
    drain();

    // Spurious result with nothing in flight.
    inj_stbs = 6'h01;
    tick();
    inj_stbs = 6'h00;
    repeat (4) tick();
    chk("spur_sticky", 384'(err_spurious), 384'(1));

    // Reset with five jobs in flight.
    lat = 20;
    req_mode[7:6] = 2'b01;
    req_valid = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      req_data[3*384 +: 384] = rnd384();
      #1;
      chk("rs_grant", 384'(req_ready), 384'(4'b1000));
      tick();
    end
    req_valid = '0;
    tick();
    chk("rs_inflight", 384'(model_out), 384'(5));
    rst = 1'b0;
    req_valid = 4'b1000;
    #1;
    chk("rs_ready", 384'(req_ready), 384'(0));
    tick();
    rst = 1'b1;
    req_valid = '0;
    repeat (3) tick();

    // Fresh job in the reset mode after the mid-flight reset.
    req_mode = '1;
    req_data[383:0] = rnd384();
    req_valid = 4'b0001;
    #1;
    chk("post_rst_ready", 384'(req_ready), 384'(4'b0001));
    tick();
    req_valid = '0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
